// File: rtl/du_dm_reader_pkg.sv
// Debug-unit data-memory dump: shared state encoding and dump sizing.
// Honours DU_DUMP_CHECKSUM_EN (adds a trailing XOR checksum byte).
package du_dm_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6,
    ST_CHK     = 3'd7
  } state_e;

  localparam int DM_WORDS       = 32;
  localparam int BYTES_PER_WORD = 4;

`ifdef DU_DUMP_CHECKSUM_EN
  localparam int DUMP_BYTES = DM_WORDS * BYTES_PER_WORD + 1;
`else
  localparam int DUMP_BYTES = DM_WORDS * BYTES_PER_WORD;
`endif

endpackage

// File: rtl/du_dm_reader.sv
// Streams every data-memory word to the UART TX, MSB byte first.
// DU_DUMP_CHECKSUM_EN appends one XOR-of-all-bytes checksum byte.
module du_dm_reader
  import du_dm_reader_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int NB_DM_ADDR = 5,
  parameter int NB_BYTE    = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [NB_DATA-1:0]    i_dm_data,
  input  logic                  i_tx_done,
  output logic                  o_du_flag,
  output logic                  o_dm_enable,
  output logic                  o_dm_read_enable,
  output logic [NB_DM_ADDR-1:0] o_dm_read_address,
  output logic                  o_tx_start,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_IDX  = $clog2(N_BYTES);

  localparam logic [NB_DM_ADDR-1:0] LAST_ADDR = '1;
  localparam logic [NB_IDX-1:0]     LAST_IDX  = NB_IDX'(N_BYTES - 1);

  state_e                state;
  state_e                state_nx;
  logic [NB_DM_ADDR-1:0] addr;
  logic [NB_IDX-1:0]     idx;
  logic [NB_DATA-1:0]    buffer;
  logic [NB_DATA-1:0]    shifted;
  logic [NB_BYTE-1:0]    cur_byte;
  logic                  active;

  // Index 0 selects the most significant byte.
  always_comb begin
    shifted  = buffer << (int'(idx) * NB_BYTE);
    cur_byte = shifted[NB_DATA-1 -: NB_BYTE];
  end

  assign active = (state != ST_IDLE) && (state != ST_DONE);

  assign o_du_flag         = active;
  assign o_dm_enable       = active;
  assign o_busy            = active;
  assign o_dm_read_address = active ? addr : '0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      addr   <= '0;
      idx    <= '0;
      buffer <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            addr <= '0;
            idx  <= '0;
          end
        end
        ST_CAPTURE: buffer <= i_dm_data;
        ST_WAIT_TX: begin
          if (i_tx_done && idx != LAST_IDX)
            idx <= idx + 1'b1;
        end
        ST_NEXT: begin
          if (addr != LAST_ADDR) begin
            addr <= addr + 1'b1;
            idx  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DU_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] chk;
  logic               chk_sent;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      chk      <= '0;
      chk_sent <= 1'b0;
    end else if (state == ST_IDLE && i_start) begin
      chk      <= '0;
      chk_sent <= 1'b0;
    end else if (state == ST_SEND) begin
      chk <= chk ^ cur_byte;
    end else if (state == ST_CHK) begin
      chk_sent <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nx         = state;
    o_dm_read_enable = 1'b0;
    o_tx_start       = 1'b0;
    o_tx_data        = '0;
    o_done           = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start)
          state_nx = ST_READ;
      end
      ST_READ: begin
        o_dm_read_enable = 1'b1;
        state_nx         = ST_CAPTURE;
      end
      ST_CAPTURE: state_nx = ST_SEND;
      ST_SEND: begin
        o_tx_start = 1'b1;
        o_tx_data  = cur_byte;
        state_nx   = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        o_tx_data = cur_byte;
        if (i_tx_done)
          state_nx = (idx == LAST_IDX) ? ST_NEXT : ST_SEND;
      end
      ST_NEXT: begin
        if (addr != LAST_ADDR)
          state_nx = ST_READ;
        else
`ifdef DU_DUMP_CHECKSUM_EN
          state_nx = ST_CHK;
`else
          state_nx = ST_DONE;
`endif
      end
      ST_DONE: begin
        o_done   = 1'b1;
        state_nx = ST_IDLE;
      end
`ifdef DU_DUMP_CHECKSUM_EN
      ST_CHK: begin
        o_tx_data = chk;
        if (!chk_sent)
          o_tx_start = 1'b1;
        else if (i_tx_done)
          state_nx = ST_DONE;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
